// File: rtl/oifs_tx_engine.sv
// FT2232H fast opto-isolated serial transmitter.
// Queues {channel, data} words in a FIFO, derives FSCLK from i_clk and
// shifts frames out on FSDI (start, data LSB-first, channel) under FSCTS.
module oifs_tx_engine #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 2,
  parameter int CTS_SYNC   = 2
) (
  input  logic                          i_clk,
  input  logic                          i_arst,
  input  logic                          i_valid,
  input  logic [DATA_W-1:0]             i_data,
  input  logic                          i_channel,
  output logic                          o_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_busy,
  input  logic                          i_fscts,
  output logic                          o_fsclk,
  output logic                          o_fsdi
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int CW   = $clog2(CLK_DIV);
  localparam int HALF = CLK_DIV / 2;
  localparam int BW   = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    CHAN,
    GAP
  } state_t;

  state_t              state;
  logic [CW-1:0]       div_cnt;
  logic [CW-1:0]       div_nxt;
  logic                tick;
  logic [CTS_SYNC-1:0] cts_sync;
  logic                w_cts;
  logic [DATA_W:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LW-1:0]       level;
  logic                push;
  logic                pop;
  logic                start_ok;
  logic [DATA_W-1:0]   shreg;
  logic                chan_bit;
  logic [BW-1:0]       bit_idx;

  assign tick     = (div_cnt == CW'(CLK_DIV - 1));
  assign div_nxt  = tick ? '0 : div_cnt + 1'b1;
  assign w_cts    = cts_sync[CTS_SYNC-1];
  assign o_ready  = (level < LW'(FIFO_DEPTH));
  assign push     = i_valid && o_ready;
  assign start_ok = ((state == IDLE) || (state == GAP)) && (level != '0) && w_cts;
  assign pop      = tick && start_ok;
  assign o_level  = level;
  assign o_busy   = (state != IDLE) || (level != '0);

  // Free-running divider; fsclk falls on the tick edge, rises at mid-period.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      div_cnt <= '0;
      o_fsclk <= 1'b1;
    end else begin
      div_cnt <= div_nxt;
      o_fsclk <= (div_nxt >= CW'(HALF));
    end
  end

  // Clear-to-send synchroniser chain.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      cts_sync <= '0;
    end else begin
      cts_sync <= {cts_sync[CTS_SYNC-2:0], i_fscts};
    end
  end

  // FIFO storage; contents are invalidated by the pointer reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= {i_channel, i_data};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Frame serialiser, advanced on ticks only.
  // The GAP tick makes the same start decision as IDLE, so the single idle
  // bit after the channel bit is the full inter-frame gap when CTS stays high.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state    <= IDLE;
      o_fsdi   <= 1'b1;
      shreg    <= '0;
      chan_bit <= 1'b0;
      bit_idx  <= '0;
    end else if (tick) begin
      case (state)
        IDLE, GAP: begin
          if (start_ok) begin
            {chan_bit, shreg} <= mem[rd_ptr];
            o_fsdi            <= 1'b0;
            state             <= START;
          end else begin
            o_fsdi <= 1'b1;
            state  <= IDLE;
          end
        end
        START: begin
          o_fsdi  <= shreg[0];
          shreg   <= shreg >> 1;
          bit_idx <= BW'(1);
          state   <= DATA;
        end
        DATA: begin
          if (bit_idx == BW'(DATA_W)) begin
            o_fsdi <= chan_bit;
            state  <= CHAN;
          end else begin
            o_fsdi  <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
        end
        CHAN: begin
          o_fsdi <= 1'b1;
          state  <= GAP;
        end
        default: begin
          o_fsdi <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oifs_tx_engine.sv
// Bench for oifs_tx_engine: a UART-style receiver model decodes FSDI at
// rising FSCLK and is scored against a queue of accepted {channel, data}.
module tb_oifs_tx_engine;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CS    = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          arst;
  logic          valid_a, ch_a, cts_a, ready_a, busy_a, fsclk_a, fsdi_a;
  logic [DW-1:0] data_a;
  logic [LW-1:0] level_a;
  logic          valid_b, ch_b, cts_b, ready_b, busy_b, fsclk_b, fsdi_b;
  logic [DW-1:0] data_b;
  logic [LW-1:0] level_b;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW:0] exp_q[$];
  logic [DW:0] rx_q[$];
  logic        raw_a[$];
  logic        raw_b[$];
  int          gaps[$];
  bit          in_fr;
  int          nbits;
  int          idle_run;
  logic [DW:0] rx_sh;

  always #5 clk = ~clk;

  oifs_tx_engine #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLK_DIV(2), .CTS_SYNC(CS)) dut (
    .i_clk(clk), .i_arst(arst), .i_valid(valid_a), .i_data(data_a), .i_channel(ch_a),
    .o_ready(ready_a), .o_level(level_a), .o_busy(busy_a), .i_fscts(cts_a),
    .o_fsclk(fsclk_a), .o_fsdi(fsdi_a)
  );

  oifs_tx_engine #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLK_DIV(6), .CTS_SYNC(CS)) dut6 (
    .i_clk(clk), .i_arst(arst), .i_valid(valid_b), .i_data(data_b), .i_channel(ch_b),
    .o_ready(ready_b), .o_level(level_b), .o_busy(busy_b), .i_fscts(cts_b),
    .o_fsclk(fsclk_b), .o_fsdi(fsdi_b)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit k is what the device should sample at the k-th rising FSCLK of a frame.
  function automatic logic [DW+2:0] frame_seq(input logic ch, input logic [DW-1:0] d);
    logic [DW+2:0] s;
    s[0] = 1'b0;
    for (int i = 0; i < DW; i++) s[1+i] = d[i];
    s[DW+1] = ch;
    s[DW+2] = 1'b1;
    return s;
  endfunction

  // Receiver model for the CLK_DIV=2 instance.
  initial forever begin
    @(posedge fsclk_a or posedge arst);
    if (arst) begin
      in_fr = 1'b0; nbits = 0; idle_run = 0; raw_a.delete();
    end else begin
      raw_a.push_back(fsdi_a);
      if (!in_fr) begin
        if (!fsdi_a) begin
          in_fr = 1'b1; nbits = 0; gaps.push_back(idle_run);
        end else begin
          idle_run++;
        end
      end else begin
        rx_sh[nbits] = fsdi_a;
        nbits++;
        if (nbits == DW + 1) begin
          rx_q.push_back(rx_sh); in_fr = 1'b0; idle_run = 0;
        end
      end
    end
  end

  // Raw sample capture for the CLK_DIV=6 instance.
  initial forever begin
    @(posedge fsclk_b or posedge arst);
    if (arst) raw_b.delete();
    else      raw_b.push_back(fsdi_b);
  end

  // FSDI may only change in the cycle FSCLK falls.
  initial begin
    logic pa, pb, ca, cb, ar;
    @(negedge clk);
    pa = fsdi_a; pb = fsdi_b; ca = fsclk_a; cb = fsclk_b; ar = arst;
    forever begin
      @(negedge clk);
      if (!arst && !ar) begin
        if (fsdi_a !== pa) chk_eq("a_fsdi_on_fall", {ca, fsclk_a}, 2'b10);
        if (fsdi_b !== pb) chk_eq("b_fsdi_on_fall", {cb, fsclk_b}, 2'b10);
      end
      pa = fsdi_a; pb = fsdi_b; ca = fsclk_a; cb = fsclk_b; ar = arst;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input bit to_b, input logic ch, input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    if (to_b) begin valid_b = 1'b1; ch_b = ch; data_b = d; end
    else      begin valid_a = 1'b1; ch_a = ch; data_a = d; end
    while (!(to_b ? ready_b : ready_a) && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) chk_eq("push_timeout", 0, 1);
    else if (!to_b) exp_q.push_back({ch, d});
    @(negedge clk);
    valid_a = 1'b0; valid_b = 1'b0;
  endtask

  task automatic check_frames(input int n);
    int t = 0;
    while (rx_q.size() < n && t < n * 200 + 200) begin @(negedge clk); t++; end
    chk_eq("rx_count", rx_q.size(), n);
    for (int i = 0; i < n; i++)
      if (rx_q.size() > 0 && exp_q.size() > 0) chk_eq("frame", rx_q.pop_front(), exp_q.pop_front());
  endtask

  task automatic wait_in_frame();
    int t = 0;
    while (!in_fr && t < 200) begin @(negedge clk); t++; end
    chk_eq("frame_start_seen", in_fr, 1);
  endtask

  initial begin
    int            idx, n0, t, lo, hi;
    bit            ones;
    logic [DW+2:0] got;
    logic [DW-1:0] d;
    logic          c;

    arst = 1'b1;
    valid_a = 0; ch_a = 0; data_a = '0; cts_a = 0;
    valid_b = 0; ch_b = 0; data_b = '0; cts_b = 1;
    repeat (3) @(negedge clk);
    chk_eq("rst_fsclk", fsclk_a, 1);
    chk_eq("rst_fsdi",  fsdi_a, 1);
    chk_eq("rst_ready", ready_a, 1);
    chk_eq("rst_level", level_a, 0);
    chk_eq("rst_busy",  busy_a, 0);
    arst = 1'b0;

    // Single frame {ch=0, A5}
    cts_a = 1'b1;
    repeat (CS + 2) @(negedge clk);
    raw_a.delete();
    push_word(0, 1'b0, 8'hA5);
    check_frames(1);
    repeat (8) @(negedge clk);
    idx = -1;
    foreach (raw_a[i]) if (idx < 0 && raw_a[i] == 1'b0) idx = i;
    chk_eq("t1_latency", (idx >= 0 && idx <= CS + 2), 1);
    if (idx >= 0 && raw_a.size() >= idx + DW + 3) begin
      for (int k = 0; k < DW + 3; k++) got[k] = raw_a[idx + k];
      chk_eq("t1_bits", got, 11'h54A);
    end else chk_eq("t1_bits_present", 0, 1);

    // Three words held back by CTS, then released
    cts_a = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) push_word(0, 1'($urandom), 8'($urandom));
    n0 = raw_a.size();
    repeat (40) @(negedge clk);
    ones = 1'b1;
    for (int i = n0; i < raw_a.size(); i++) if (raw_a[i] !== 1'b1) ones = 1'b0;
    chk_eq("t2_fsdi_idle", ones, 1);
    chk_eq("t2_level", level_a, 3);
    chk_eq("t2_busy", busy_a, 1);
    chk_eq("t2_no_rx", rx_q.size(), 0);
    gaps.delete();
    cts_a = 1'b1;
    check_frames(3);
    chk_eq("t2_gap1", (gaps.size() >= 3 && gaps[1] >= 1), 1);
    chk_eq("t2_gap2", (gaps.size() >= 3 && gaps[2] >= 1), 1);

    // Fill to full with CTS low
    cts_a = 1'b0;
    repeat (30) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) push_word(0, 1'($urandom), 8'($urandom));
    chk_eq("t3_level_full", level_a, DEPTH);
    chk_eq("t3_ready_full", ready_a, 0);
    valid_a = 1'b1; data_a = 8'($urandom); ch_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    @(negedge clk);
    chk_eq("t3_17th_ignored", level_a, DEPTH);
    cts_a = 1'b1;
    t = 0;
    while (level_a != LW'(DEPTH - 1) && t < 200) begin @(negedge clk); t++; end
    chk_eq("t3_ready_after_pop", ready_a, 1);
    check_frames(DEPTH);

    // CTS dropped mid-frame
    repeat (30) @(negedge clk);
    push_word(0, 1'b1, 8'($urandom));
    push_word(0, 1'b0, 8'($urandom));
    wait_in_frame();
    repeat (6) @(negedge clk);
    cts_a = 1'b0;
    check_frames(1);
    repeat (60) @(negedge clk);
    chk_eq("t4_held", rx_q.size(), 0);
    chk_eq("t4_level", level_a, 1);
    cts_a = 1'b1;
    check_frames(1);

    // Random traffic with random source gaps
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      push_word(0, 1'($urandom), 8'($urandom));
    end
    check_frames(20);

    // CLK_DIV=6 instance: period, duty and one frame
    t = 0;
    while (fsclk_b !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    while (fsclk_b !== 1'b0 && t < 40) begin @(negedge clk); t++; end
    lo = 0; hi = 0;
    while (fsclk_b === 1'b0 && lo < 20) begin @(negedge clk); lo++; end
    while (fsclk_b === 1'b1 && hi < 20) begin @(negedge clk); hi++; end
    chk_eq("b_fsclk_low", lo, 3);
    chk_eq("b_fsclk_high", hi, 3);
    raw_b.delete();
    d = 8'($urandom); c = 1'b1;
    push_word(1, c, d);
    repeat (150) @(negedge clk);
    idx = -1;
    foreach (raw_b[i]) if (idx < 0 && raw_b[i] == 1'b0) idx = i;
    if (idx >= 0 && raw_b.size() >= idx + DW + 3) begin
      for (int k = 0; k < DW + 3; k++) got[k] = raw_b[idx + k];
      chk_eq("b_bits", got, frame_seq(c, d));
    end else chk_eq("b_bits_present", 0, 1);
    chk_eq("b_idle_level", level_b, 0);
    chk_eq("b_idle_busy", busy_b, 0);

    // Reset in the middle of DATA
    repeat (10) @(negedge clk);
    push_word(0, 1'($urandom), 8'($urandom));
    push_word(0, 1'($urandom), 8'($urandom));
    wait_in_frame();
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 arst = 1'b1;
    #1;
    chk_eq("t6_fsdi", fsdi_a, 1);
    chk_eq("t6_fsclk", fsclk_a, 1);
    chk_eq("t6_level", level_a, 0);
    chk_eq("t6_busy", busy_a, 0);
    exp_q.delete();
    rx_q.delete();
    repeat (2) @(negedge clk);
    arst = 1'b0;
    repeat (CS + 2) @(negedge clk);
    push_word(0, 1'b1, 8'h3C);
    check_frames(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/oifs_tx_engine.md
Name: oifs_tx_engine

Overview:
- Parametrised FT2232H fast opto-isolated serial (OIFS) transmitter. It replaces the bare TX interface with fixed external clock toggling.
- Accepts {channel, data} words on a valid-ready port into an internal FIFO.
- Generates FSCLK internally from i_clk with a programmable divider.
- Serialises frames on FSDI under FSCTS flow control.
- Sits between host-side stream logic and the FT2232H fast serial pins.

Parameters:
DATA_W, 8, payload bits per frame
FIFO_DEPTH, 16, FIFO entries; power of two, >=2
CLK_DIV, 2, i_clk cycles per FSCLK period; even, >=2
CTS_SYNC, 2, synchroniser flops on i_fscts, >=2

Ports:
i_clk  in  1  system clock
i_arst  in  1  reset
i_valid  in  1  input word valid
i_data  in  DATA_W  payload
i_channel  in  1  destination channel bit (0=A, 1=B)
o_ready  out  1  FIFO can accept a word
o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
o_busy  out  1  frame in progress or FIFO non-empty
i_fscts  in  1  device clear-to-send (asynchronous)
o_fsclk  out  1  serial clock to device
o_fsdi  out  1  serial data to device

Behaviour:
- Reset: i_arst, asynchronous, active-high; clock i_clk.
- Output reset values: o_fsclk=1, o_fsdi=1, o_ready=1, o_level=0, o_busy=0. Divider counter=0, FIFO empty, state IDLE.
- Clock generation:
  - Free-running divider counts 0..CLK_DIV-1.
  - o_fsclk=0 while counter < CLK_DIV/2, 1 otherwise. It is a registered output.
  - "tick" is the cycle the counter wraps to 0, i.e. the fsclk falling edge.
  - All o_fsdi changes occur only on ticks. The device samples on the rising edge, giving a half period of setup.
- FIFO:
  - Write when i_valid && o_ready. o_ready = (level < FIFO_DEPTH).
  - Read pops one entry at frame start.
  - A simultaneous write and pop leaves level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Writes while full are ignored; i_valid is held by the source.
- CTS: i_fscts passes through CTS_SYNC flops. w_cts is the synchronised value.
- FSM, evaluated on ticks only:
  - IDLE: o_fsdi=1. If FIFO non-empty && w_cts=1: pop, load shift register {channel, data}, drive start bit 0, go START.
  - START: drive data[0], bit index=1, go DATA.
  - DATA: drive data[idx], LSB first. After data[DATA_W-1] has been driven for one bit, drive channel bit and go CHAN.
  - CHAN: drive 1, go GAP.
  - GAP: hold o_fsdi=1 for at least one full bit, then return to IDLE.
  - IDLE requires w_cts=1 again. The device drops FSCTS after a frame; this guards the CTS round-trip.
- Frame: 1 start + DATA_W data + 1 channel = DATA_W+2 bits, then >=1 idle bit.
- Back-to-back minimum frame spacing: DATA_W+3 FSCLK periods when CTS stays high.
- CTS deassert mid-frame: the frame completes unchanged. CTS is only checked in IDLE.
- o_busy = (state != IDLE) || (level != 0).
- Reset mid-frame: outputs return to reset values immediately and the FIFO contents are discarded. The device sees o_fsdi=1 and treats the partial frame as aborted.

Test Plan:
- Reset, then fscts=1, push {ch=0, data=0xA5} with CLK_DIV=2 -> o_fsdi at successive rising fsclk edges: 0,1,0,1,0,0,1,0,1,0 (start, LSB-first A5, ch 0), then 1. Frame begins within CTS_SYNC+2 fsclk periods.
- fscts=0, push 3 words -> o_fsdi stays 1 and o_level=3. Raise fscts -> three frames emitted in order, with >=1 idle bit between frames and the channel bits matching.
- Fill FIFO_DEPTH=16 with fscts=0 -> o_ready=0 at level 16. A 17th valid word is not accepted. After one pop, o_ready=1.
- Drop fscts in the middle of frame 1 of 2 -> frame 1 completes fully. Frame 2 waits until fscts returns high.
- CLK_DIV=6 -> o_fsclk period is 6 cycles with 50% duty. o_fsdi changes only in the cycle fsclk falls.
- Assert i_arst mid-DATA -> same cycle: o_fsdi=1, o_fsclk=1, o_level=0, o_busy=0. After release, a new frame transmits correctly.
